// File: rtl/frame_packer_sc.sv
// frame_packer_sc: packs triggered TDATA beats into header/data/footer frames
// and replays them store-and-forward as 64-bit words with output backpressure.
// Ports: CLK, RESETN (async, active-low); iVALID/DIN in, oREADY out;
//   iREADY in, oVALID/DOUT/oLAST out (oLAST marks the footer word).
// Build option: FRAME_PACKER_DROP_CNT_EN puts the drop counter in header[27:16].
module frame_packer_sc #(
  parameter int         TDATA_WIDTH      = 128,
  parameter int         DOUT_WIDTH       = 64,
  parameter int         MAX_FRAME_LEN    = 200,
  parameter int         DATA_DEPTH       = 512,
  parameter int         INFO_DEPTH       = 16,
  parameter logic [3:0] CHANNEL_ID       = 4'd0,
  parameter int         TIME_STAMP_WIDTH = 48,
  parameter int         ADC_RES_WIDTH    = 12
) (
  input  logic                   CLK,
  input  logic                   RESETN,
  input  logic                   iVALID,
  input  logic [TDATA_WIDTH+TIME_STAMP_WIDTH+2*ADC_RES_WIDTH:0] DIN,
  output logic                   oREADY,
  input  logic                   iREADY,
  output logic                   oVALID,
  output logic [DOUT_WIDTH-1:0]  DOUT,
  output logic                   oLAST
);
  localparam int TW  = TDATA_WIDTH;
  localparam int DW  = DOUT_WIDTH;
  localparam int TSW = TIME_STAMP_WIDTH;
  localparam int AW  = ADC_RES_WIDTH;
  localparam int K   = TW / DW;
  localparam int DAW = $clog2(DATA_DEPTH);
  localparam int IAW = $clog2(INFO_DEPTH);
  localparam int BW  = $clog2(MAX_FRAME_LEN + 1);
  localparam int SW  = (K > 1) ? $clog2(K) : 1;
  localparam logic [BW-1:0]  BMAX  = BW'(MAX_FRAME_LEN);
  localparam logic [DAW:0]   DLIM  = (DAW+1)'(DATA_DEPTH - MAX_FRAME_LEN);
  localparam logic [IAW:0]   IFULL = (IAW+1)'(INFO_DEPTH);
  localparam logic [SW-1:0]  SLAST = SW'(K - 1);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_FTR} st_t;

  logic [TW-1:0]  td_w;
  logic [TSW-1:0] ts_w;
  logic [AW-1:0]  bl_w;
  logic [AW:0]    th_w;
  assign td_w = DIN[TW+TSW+2*AW -: TW];
  assign ts_w = DIN[TSW+2*AW -: TSW];
  assign bl_w = DIN[2*AW -: AW];
  assign th_w = DIN[AW:0];

  logic           ready_q;
  logic           open_q, open_d, acc_q, acc_d;
  logic [BW-1:0]  beats_q, beats_d, cur_b;
  logic [TSW-1:0] ts_q, ts_d, f_ts;
  logic [AW-1:0]  bl_q, bl_d, f_bl;
  logic [AW:0]    th_q, th_d, f_th;
  logic [11:0]    f_dc;
  logic [15:0]    len_w;
  logic           vin, opening, admit, take;
  logic           close_max, close_fall, dwr, ipush;

  logic [TW-1:0]   dmem [DATA_DEPTH];
  logic [2*DW-1:0] imem [INFO_DEPTH];
  logic [DAW-1:0]  dwp_q, drp_q;
  logic [IAW-1:0]  iwp_q, irp_q;
  logic [DAW:0]    dcnt_q;
  logic [IAW:0]    icnt_q;
  logic            dpop, ipop;

  assign oREADY = ready_q;
  assign vin    = iVALID & ready_q;

  always_comb begin
    opening    = vin & ~open_q;
    cur_b      = open_q ? beats_q + BW'(1) : BW'(1);
    admit      = (dcnt_q <= DLIM) && (icnt_q != IFULL);
    take       = open_q ? acc_q : admit;
    dwr        = vin & take;
    close_max  = vin & (cur_b == BMAX);
    close_fall = open_q & ~vin;
    // store-and-forward: info becomes visible only once all data is written
    ipush      = (close_max | close_fall) & take;
    len_w      = 16'(vin ? cur_b : beats_q) * 16'(K);
    f_ts       = open_q ? ts_q : ts_w;
    f_bl       = open_q ? bl_q : bl_w;
    f_th       = open_q ? th_q : th_w;
  end

  always_comb begin
    open_d  = open_q;
    acc_d   = acc_q;
    beats_d = beats_q;
    ts_d    = ts_q;
    bl_d    = bl_q;
    th_d    = th_q;
    if (close_max | close_fall) begin
      open_d = 1'b0;
    end else begin
      if (opening) begin
        open_d = 1'b1;
        acc_d  = admit;
        ts_d   = ts_w;
        bl_d   = bl_w;
        th_d   = th_w;
      end
      if (vin) beats_d = cur_b;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      ready_q <= 1'b0;
      open_q  <= 1'b0;
      acc_q   <= 1'b0;
      beats_q <= '0;
      ts_q    <= '0;
      bl_q    <= '0;
      th_q    <= '0;
    end else begin
      ready_q <= 1'b1;
      open_q  <= open_d;
      acc_q   <= acc_d;
      beats_q <= beats_d;
      ts_q    <= ts_d;
      bl_q    <= bl_d;
      th_q    <= th_d;
    end
  end

`ifdef FRAME_PACKER_DROP_CNT_EN
  logic [11:0] drop_q, dsnap_q;
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      drop_q  <= '0;
      dsnap_q <= '0;
    end else if (opening) begin
      dsnap_q <= drop_q;
      if (!admit && drop_q != 12'hFFF) drop_q <= drop_q + 12'd1;
    end
  end
  assign f_dc = open_q ? dsnap_q : drop_q;
`else
  assign f_dc = 12'h000;
`endif

  always_ff @(posedge CLK) begin
    if (dwr) dmem[dwp_q] <= td_w;
    if (ipush) imem[iwp_q] <= {8'hFF, CHANNEL_ID, f_ts[47:24], f_dc, len_w,
                               4'hF, f_bl, 3'h7, f_th, f_ts[23:0], 8'h0F};
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      dwp_q  <= '0;
      drp_q  <= '0;
      iwp_q  <= '0;
      irp_q  <= '0;
      dcnt_q <= '0;
      icnt_q <= '0;
    end else begin
      dwp_q  <= dwp_q + DAW'(dwr);
      drp_q  <= drp_q + DAW'(dpop);
      iwp_q  <= iwp_q + IAW'(ipush);
      irp_q  <= irp_q + IAW'(ipop);
      dcnt_q <= dcnt_q + (DAW+1)'(dwr) - (DAW+1)'(dpop);
      icnt_q <= icnt_q + (IAW+1)'(ipush) - (IAW+1)'(ipop);
    end
  end

  st_t             st_q, st_d;
  logic [DW-1:0]   dout_q, dout_d;
  logic            ov_q, ov_d, ol_q, ol_d;
  logic [15:0]     wcnt_q, wcnt_d;
  logic [SW-1:0]   sub_q, sub_d;
  logic [TW-1:0]   dhead;
  logic [2*DW-1:0] ihead;
  logic            ld, more;

  assign dhead = dmem[drp_q];
  assign ihead = imem[irp_q];
  // output register may take a new word when empty or being consumed
  assign ld    = ~ov_q | iREADY;
  assign more  = (icnt_q > (IAW+1)'(1)) | ipush;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) st_q <= S_IDLE;
    else         st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      S_IDLE: if (icnt_q != '0) st_d = S_HDR;
      S_HDR:  if (ld) st_d = S_DATA;
      S_DATA: if (ld && wcnt_q == 16'd1) st_d = S_FTR;
      S_FTR:  if (ld) st_d = more ? S_HDR : S_IDLE;
      default: st_d = S_IDLE;
    endcase
  end

  always_comb begin
    dout_d = dout_q;
    ov_d   = ov_q;
    ol_d   = ol_q;
    wcnt_d = wcnt_q;
    sub_d  = sub_q;
    dpop   = 1'b0;
    ipop   = 1'b0;
    if (ld) begin
      dout_d = '0;
      ov_d   = 1'b0;
      ol_d   = 1'b0;
      case (st_q)
        S_HDR: begin
          dout_d = ihead[2*DW-1:DW];
          ov_d   = 1'b1;
          wcnt_d = ihead[DW+15:DW];
          sub_d  = '0;
        end
        S_DATA: begin
          dout_d = dhead[(K-1-int'(sub_q))*DW +: DW];
          ov_d   = 1'b1;
          wcnt_d = wcnt_q - 16'd1;
          if (sub_q == SLAST) begin
            sub_d = '0;
            dpop  = 1'b1;
          end else begin
            sub_d = sub_q + SW'(1);
          end
        end
        S_FTR: begin
          dout_d = ihead[DW-1:0];
          ov_d   = 1'b1;
          ol_d   = 1'b1;
          ipop   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      dout_q <= '0;
      ov_q   <= 1'b0;
      ol_q   <= 1'b0;
      wcnt_q <= '0;
      sub_q  <= '0;
    end else begin
      dout_q <= dout_d;
      ov_q   <= ov_d;
      ol_q   <= ol_d;
      wcnt_q <= wcnt_d;
      sub_q  <= sub_d;
    end
  end

  assign oVALID = ov_q;
  assign DOUT   = dout_q;
  assign oLAST  = ol_q;
endmodule

// File: tb/tb_frame_packer_sc.sv
// tb_frame_packer_sc: directed bench for frame_packer_sc (default parameters).
// Covers format, max-length split, stalls, drops, mid-frame reset, info-full.
module tb_frame_packer_sc;
  localparam logic [11:0] BL = 12'h123;
  localparam logic [12:0] TH = 13'h0ABC;
`ifdef FRAME_PACKER_DROP_CNT_EN
  localparam logic [11:0] DC1 = 12'd1;
`else
  localparam logic [11:0] DC1 = 12'd0;
`endif

  logic         CLK = 1'b0;
  logic         RESETN = 1'b0;
  logic         iVALID = 1'b0;
  logic         iREADY = 1'b1;
  logic [200:0] DIN = '0;
  logic         oREADY, oVALID, oLAST;
  logic [63:0]  DOUT;
  int           total = 0;
  int           bad = 0;
  logic [64:0]  q[$];
  logic [64:0]  e1 [10];
  logic         pv, pr;
  logic [63:0]  pd;

  frame_packer_sc dut (
    .CLK(CLK), .RESETN(RESETN), .iVALID(iVALID), .DIN(DIN),
    .oREADY(oREADY), .iREADY(iREADY), .oVALID(oVALID),
    .DOUT(DOUT), .oLAST(oLAST)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK)
    if (RESETN && oVALID && iREADY) q.push_back({oLAST, DOUT});

  function automatic logic [127:0] td(int tag, int b);
    return {8'hA0, 8'(tag), 48'(b), 8'h50, 8'(tag), 48'(b)};
  endfunction

  function automatic logic [63:0] eh(logic [47:0] ts, logic [11:0] dc, int len);
    return {8'hFF, 4'h0, ts[47:24], dc, 16'(len)};
  endfunction

  function automatic logic [63:0] ef(logic [47:0] ts);
    return {4'hF, BL, 3'h7, TH, ts[23:0], 8'h0F};
  endfunction

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(string tag, logic [64:0] obs, logic [64:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(int n, int tag, logic [47:0] ts0);
    for (int b = 0; b < n; b++) begin
      iVALID = 1'b1;
      DIN = {td(tag, b), ts0 + 48'(b), BL, TH};
      tick;
    end
    iVALID = 1'b0;
    tick;
  endtask

  task automatic waitq(string tag, int n, int budget);
    int c = 0;
    while (q.size() < n && c < budget) begin
      tick;
      c++;
    end
    repeat (4) tick;
    chk(tag, 65'(q.size()), 65'(n));
  endtask

  task automatic chk_frame(string tag, int at, int tg, int b0, int n,
                           logic [47:0] ts, logic [11:0] dc);
    chk({tag, ".hdr"}, q[at], {1'b0, eh(ts, dc, 2 * n)});
    for (int i = 0; i < n; i++) begin
      logic [127:0] d;
      d = td(tg, b0 + i);
      chk({tag, ".dhi"}, q[at + 1 + 2 * i], {1'b0, d[127:64]});
      chk({tag, ".dlo"}, q[at + 2 + 2 * i], {1'b0, d[63:0]});
    end
    chk({tag, ".ftr"}, q[at + 1 + 2 * n], {1'b1, ef(ts)});
  endtask

  initial begin
    e1[0] = {1'b0, 64'hFF01234560000006};
    e1[1] = {1'b0, 64'hA001000000000000};
    e1[2] = {1'b0, 64'h5001000000000000};
    e1[3] = {1'b0, 64'hA001000000000001};
    e1[4] = {1'b0, 64'h5001000000000001};
    e1[5] = {1'b0, 64'hA001000000000002};
    e1[6] = {1'b0, 64'h5001000000000002};
    e1[7] = {1'b1, 64'hF123EABC789ABC0F};
    e1[8] = 65'h0;
    e1[9] = 65'h0;
    pv = 1'b0;
    pr = 1'b0;
    pd = '0;

    #2;
    chk("rst.valid", 65'(oVALID), 65'd0);
    chk("rst.last", 65'(oLAST), 65'd0);
    chk("rst.dout", 65'(DOUT), 65'd0);
    chk("rst.ready", 65'(oREADY), 65'd0);
    tick;
    tick;
    RESETN = 1'b1;
    tick;
    chk("ready", 65'(oREADY), 65'd1);

    // 1: three beats, hand-computed words and header latency
    send(3, 1, 48'h1234_5678_9ABC);
    @(negedge CLK);
    chk("t1.lat0", 65'(oVALID), 65'd0);
    @(negedge CLK);
    chk("t1.lat1", 65'(oVALID), 65'd0);
    @(negedge CLK);
    chk("t1.lat2", 65'(oVALID), 65'd1);
    @(posedge CLK);
    #1;
    waitq("t1.n", 8, 50);
    for (int i = 0; i < 8; i++) chk("t1.w", q[i], e1[i]);
    q.delete();

    // 2: 450 beats split at 200
    send(450, 2, 48'h0000_0100_0000);
    waitq("t2.n", 906, 2000);
    chk_frame("t2a", 0, 2, 0, 200, 48'h0000_0100_0000, 12'd0);
    chk_frame("t2b", 402, 2, 200, 200, 48'h0000_0100_00C8, 12'd0);
    chk_frame("t2c", 804, 2, 400, 50, 48'h0000_0100_0190, 12'd0);
    q.delete();

    // 3: iREADY 1-0-0-1 pattern, held words while stalled
    iREADY = 1'b0;
    send(4, 3, 48'h0000_0300_0000);
    for (int c = 0; c < 60; c++) begin
      iREADY = (c % 4 == 1 || c % 4 == 2) ? 1'b0 : 1'b1;
      @(negedge CLK);
      if (pv && !pr) chk("t3.hold", {oVALID, DOUT}, {1'b1, pd});
      pv = oVALID;
      pr = iREADY;
      pd = DOUT;
      @(posedge CLK);
      #1;
    end
    iREADY = 1'b1;
    waitq("t3.n", 10, 50);
    chk_frame("t3", 0, 3, 0, 4, 48'h0000_0300_0000, 12'd0);
    q.delete();

    // 4: fill to 412 words while stalled, next frame dropped whole
    iREADY = 1'b0;
    send(150, 4, 48'h0000_0400_0000);
    send(150, 5, 48'h0000_0500_0000);
    send(112, 6, 48'h0000_0600_0000);
    send(5, 7, 48'h0000_0700_0000);
    iREADY = 1'b1;
    waitq("t4.n", 830, 3000);
    chk_frame("t4a", 0, 4, 0, 150, 48'h0000_0400_0000, 12'd0);
    chk_frame("t4b", 302, 5, 0, 150, 48'h0000_0500_0000, 12'd0);
    chk_frame("t4c", 604, 6, 0, 112, 48'h0000_0600_0000, 12'd0);
    q.delete();
    send(2, 8, 48'h0000_0800_0000);
    waitq("t4e.n", 6, 50);
    chk_frame("t4e", 0, 8, 0, 2, 48'h0000_0800_0000, DC1);
    q.delete();

    // 5: reset pulse in the middle of the data phase
    send(20, 9, 48'h0000_0900_0000);
    repeat (5) tick;
    chk("t5.pre", 65'(oVALID), 65'd1);
    RESETN = 1'b0;
    #1;
    chk("t5.valid", 65'(oVALID), 65'd0);
    chk("t5.dout", 65'(DOUT), 65'd0);
    chk("t5.last", 65'(oLAST), 65'd0);
    chk("t5.ready", 65'(oREADY), 65'd0);
    tick;
    RESETN = 1'b1;
    q.delete();
    repeat (10) tick;
    chk("t5.stale", 65'(q.size()), 65'd0);
    chk("t5.idle", 65'(oVALID), 65'd0);
    send(2, 10, 48'h0000_0A00_0000);
    waitq("t5.n", 6, 50);
    chk_frame("t5", 0, 10, 0, 2, 48'h0000_0A00_0000, 12'd0);
    q.delete();

    // 6: single-beat frames until the info FIFO is full
    iREADY = 1'b0;
    for (int f = 0; f < 17; f++) send(1, 16 + f, 48'h0000_0B00_0000 + 48'(f * 16));
    iREADY = 1'b1;
    waitq("t6.n", 64, 500);
    for (int f = 0; f < 16; f++)
      chk_frame("t6", 4 * f, 16 + f, 0, 1, 48'h0000_0B00_0000 + 48'(f * 16), 12'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
